// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment reader: glyph patterns (seg_a is bit 6),
// the capture FSM state type and the width of one recovered digit value.
package seven_seg_pkg;

    localparam int DIGIT_W = 3;

    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_E = 7'b1001111;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURED
    } state_t;

endpackage

// File: rtl/seven_segment_pattern_dec.sv
// Combinational glyph decoder: 7-bit segment pattern -> 3-bit value plus error flag.
module seven_segment_pattern_dec
    import seven_seg_pkg::*;
(
    input  logic [6:0]         pattern,
    output logic [DIGIT_W-1:0] value,
    output logic               err
);

    always_comb begin
        value = '0;
        err   = 1'b0;
        case (pattern)
            SEG_0:   value = 3'd0;
            SEG_1:   value = 3'd1;
            SEG_2:   value = 3'd2;
            SEG_3:   value = 3'd3;
            SEG_4:   value = 3'd4;
            SEG_5:   value = 3'd5;
            SEG_6:   value = 3'd6;
            SEG_7:   value = 3'd7;
            // SEG_E and any unlisted pattern report value 0 with the error flag
            default: err   = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_segment_reader.sv
// Recovers digit values from a multiplexed seven-segment bus and publishes whole frames.
// Build option: define SEG_ACTIVE_LOW_EN for common-anode panels (segment lines inverted).
module seven_segment_reader
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_DIGITS-1:0]         dig_sel,
    input  logic                          seg_a,
    input  logic                          seg_b,
    input  logic                          seg_c,
    input  logic                          seg_d,
    input  logic                          seg_e,
    input  logic                          seg_f,
    input  logic                          seg_g,
    output logic [DIGIT_W*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]         digit_err,
    output logic                          frame_valid,
    output logic                          frame_err
);

    localparam int              CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [6:0] pat_raw;
    logic [6:0] pat_in;

    assign pat_raw = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};
`ifdef SEG_ACTIVE_LOW_EN
    assign pat_in = ~pat_raw;
`else
    assign pat_in = pat_raw;
`endif

    logic [NUM_DIGITS-1:0]         s_sel_reg, p_sel_reg;
    logic [6:0]                    s_pat_reg, p_pat_reg;
    state_t                        state_reg, state_next;
    logic [CNT_W-1:0]              cnt_reg, cnt_next;
    logic [NUM_DIGITS-1:0]         mask_reg, mask_next;
    logic [DIGIT_W*NUM_DIGITS-1:0] stage_val, digits_reg;
    logic [NUM_DIGITS-1:0]         stage_err, digit_err_reg, cap_bits;
    logic                          frame_valid_reg, frame_err_reg;
    logic                          one_hot, same, capture, frame_done;
    logic [DIGIT_W-1:0]            dec_val;
    logic                          dec_err;

    seven_segment_pattern_dec u_dec (
        .pattern (s_pat_reg),
        .value   (dec_val),
        .err     (dec_err)
    );

    assign one_hot    = $onehot(s_sel_reg);
    assign same       = ({s_sel_reg, s_pat_reg} == {p_sel_reg, p_pat_reg});
    assign cap_bits   = capture ? s_sel_reg : '0;
    assign frame_done = &mask_reg;

    // Sample register plus a copy of the previous sample for change detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_sel_reg <= '0;
            s_pat_reg <= '0;
            p_sel_reg <= '0;
            p_pat_reg <= '0;
        end else begin
            s_sel_reg <= dig_sel;
            s_pat_reg <= pat_in;
            p_sel_reg <= s_sel_reg;
            p_pat_reg <= s_pat_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (one_hot) begin
                    state_next = SETTLE;
                    cnt_next   = CNT_ONE;
                end
            end
            SETTLE: begin
                if (!one_hot) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (same) begin
                    cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_ONE;
                end else begin
                    cnt_next = CNT_ONE;
                end
            end
            CAPTURED: begin
                if (!same) begin
                    state_next = one_hot ? SETTLE : IDLE;
                    cnt_next   = one_hot ? CNT_ONE : '0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
        // Capture on the same edge the count reaches the threshold, so STABLE_CYCLES=1 works
        if (state_next == SETTLE && cnt_next == CNT_MAX) begin
            capture    = 1'b1;
            state_next = CAPTURED;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
            logic [DIGIT_W-1:0] val_reg;
            logic               err_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    val_reg <= '0;
                    err_reg <= 1'b0;
                end else if (cap_bits[gi]) begin
                    val_reg <= dec_val;
                    err_reg <= dec_err;
                end
            end

            assign stage_val[gi*DIGIT_W +: DIGIT_W] = val_reg;
            assign stage_err[gi]                    = err_reg;
        end
    endgenerate

    // A capture coinciding with publication lands in the freshly cleared mask
    assign mask_next = frame_done ? cap_bits : (mask_reg | cap_bits);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_reg        <= '0;
            digits_reg      <= '0;
            digit_err_reg   <= '0;
            frame_valid_reg <= 1'b0;
            frame_err_reg   <= 1'b0;
        end else begin
            mask_reg        <= mask_next;
            frame_valid_reg <= frame_done;
            if (frame_done) begin
                digits_reg    <= stage_val;
                digit_err_reg <= stage_err;
                frame_err_reg <= |stage_err;
            end
        end
    end

    assign digits      = digits_reg;
    assign digit_err   = digit_err_reg;
    assign frame_valid = frame_valid_reg;
    assign frame_err   = frame_err_reg;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Bench for seven_segment_reader: run-length reference model checked every cycle plus
// directed scans with hand-computed frames; honours SEG_ACTIVE_LOW_EN when driving pins.
module tb_seven_segment_reader;

    localparam int ND = 4;
    localparam int SC = 8;
    localparam logic [6:0] GLYPH [8] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000};
    localparam logic [6:0] P0 = 7'b1111110, P1 = 7'b0110000, P2 = 7'b1101101, P3 = 7'b1111001;
    localparam logic [6:0] P4 = 7'b0110011, P5 = 7'b1011011, P6 = 7'b1011111, P7 = 7'b1110000;
    localparam logic [6:0] PE = 7'b1001111;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [ND-1:0] dig_sel;
    logic [6:0]    pins, drv;
    logic [3*ND-1:0] digits;
    logic [ND-1:0] digit_err;
    logic          frame_valid, frame_err;

    int checks = 0;
    int errors = 0;
    int frames = 0;

`ifdef SEG_ACTIVE_LOW_EN
    assign drv = ~pins;
`else
    assign drv = pins;
`endif

    seven_segment_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n), .dig_sel(dig_sel),
        .seg_a(drv[6]), .seg_b(drv[5]), .seg_c(drv[4]), .seg_d(drv[3]),
        .seg_e(drv[2]), .seg_f(drv[1]), .seg_g(drv[0]),
        .digits(digits), .digit_err(digit_err), .frame_valid(frame_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a digit is captured when its {sel,pattern} sample has been seen
    // exactly SC times in a row; a frame is published one cycle after all slots fill.
    logic [ND+6:0]   m_samp;
    int              m_run;
    int              m_val [ND];
    bit              m_err [ND];
    logic [ND-1:0]   m_mask;
    logic [3*ND-1:0] e_digits;
    logic [ND-1:0]   e_derr;
    bit              e_valid, e_ferr;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_samp = '0; m_run = 1; m_mask = '0;
                e_digits = '0; e_derr = '0; e_valid = 0; e_ferr = 0;
                for (int d = 0; d < ND; d++) begin m_val[d] = 0; m_err[d] = 0; end
            end else begin
                e_valid = 0;
                if (m_mask == {ND{1'b1}}) begin
                    e_ferr = 0;
                    for (int d = 0; d < ND; d++) begin
                        e_digits[3*d +: 3] = 3'(m_val[d]);
                        e_derr[d] = m_err[d];
                        e_ferr = e_ferr | m_err[d];
                    end
                    e_valid = 1;
                    m_mask = '0;
                end
                if ($onehot(m_samp[ND+6:7]) && m_run == SC) begin
                    for (int d = 0; d < ND; d++) begin
                        if (m_samp[7+d]) begin
                            m_val[d] = 0; m_err[d] = 1;
                            for (int k = 0; k < 8; k++)
                                if (m_samp[6:0] == GLYPH[k]) begin m_val[d] = k; m_err[d] = 0; end
                            m_mask[d] = 1'b1;
                        end
                    end
                end
                if ({dig_sel, pins} == m_samp) m_run = (m_run < 1000) ? m_run + 1 : m_run;
                else m_run = 1;
                m_samp = {dig_sel, pins};
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            check("model_digits", 32'(digits), 32'(e_digits));
            check("model_digit_err", 32'(digit_err), 32'(e_derr));
            check("model_frame_valid", 32'(frame_valid), 32'(e_valid));
            check("model_frame_err", 32'(frame_err), 32'(e_ferr));
            if (frame_valid) frames++;
        end
    end

    task automatic show(input logic [ND-1:0] sel, input logic [6:0] pat, input int n);
        dig_sel = sel;
        pins    = pat;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [6:0] a, b, c, d, input int n2);
        show(4'b0001, a, 10);
        show(4'b0010, b, 10);
        show(4'b0100, c, n2);
        show(4'b1000, d, 10);
        show(4'b0000, 7'd0, 4);
    endtask

    int f0;

    initial begin
        rst_n = 1'b0; dig_sel = '0; pins = '0;
        @(negedge clk);
        // Reset held with an active digit on the bus
        show(4'b0001, P2, 5);
        check("reset_digits", 32'(digits), 32'd0);
        check("reset_digit_err", 32'(digit_err), 32'd0);
        check("reset_frame_valid", 32'(frame_valid), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        show(4'b0000, 7'd0, 3);

        // Basic scan of values 2,1,3,6
        f0 = frames;
        scan(P2, P1, P3, P6, 10);
        check("scan_frames", 32'(frames - f0), 32'd1);
        check("scan_digits", 32'(digits), 32'(12'b110_011_001_010));
        check("scan_digit_err", 32'(digit_err), 32'd0);
        check("scan_frame_err", 32'(frame_err), 32'd0);

        // Digit 2 too short: no frame until it is shown long enough
        f0 = frames;
        scan(P7, P6, P5, P4, 5);
        check("short_no_frame", 32'(frames - f0), 32'd0);
        show(4'b0100, P5, 10);
        show(4'b0000, 7'd0, 4);
        check("short_late_frame", 32'(frames - f0), 32'd1);
        check("short_digits", 32'(digits), 32'(12'b100_101_110_111));

        // Error glyph on digit 1
        f0 = frames;
        scan(P0, PE, P1, P2, 10);
        check("err_frames", 32'(frames - f0), 32'd1);
        check("err_digit_err", 32'(digit_err), 32'(4'b0010));
        check("err_digits", 32'(digits), 32'(12'b010_001_000_000));
        check("err_frame_err", 32'(frame_err), 32'd1);

        // Multi-hot and blank strobes interrupt settling of digit 0
        f0 = frames;
        show(4'b0001, P4, 5);
        show(4'b0110, P4, 1);
        show(4'b0001, P4, 5);
        show(4'b0000, P4, 1);
        show(4'b0001, P4, 5);
        show(4'b0010, P3, 10);
        show(4'b0100, P3, 10);
        show(4'b1000, P3, 10);
        show(4'b0000, 7'd0, 4);
        check("glitch_no_frame", 32'(frames - f0), 32'd0);
        check("glitch_ferr_held", 32'(frame_err), 32'd1);
        show(4'b0001, P4, 10);
        show(4'b0000, 7'd0, 4);
        check("glitch_frame", 32'(frames - f0), 32'd1);
        check("glitch_digits", 32'(digits), 32'(12'b011_011_011_100));
        check("glitch_frame_err", 32'(frame_err), 32'd0);

        // Reset mid-frame discards captured digits 0 and 1
        show(4'b0001, P1, 10);
        show(4'b0010, P1, 10);
        rst_n = 1'b0;
        show(4'b0000, 7'd0, 2);
        check("midrst_digits", 32'(digits), 32'd0);
        rst_n = 1'b1;
        f0 = frames;
        show(4'b0100, P1, 10);
        show(4'b1000, P1, 10);
        show(4'b0000, 7'd0, 4);
        check("midrst_no_frame", 32'(frames - f0), 32'd0);

        // Recapture of digit 0 before the frame completes overwrites its slot
        show(4'b0001, P2, 10);
        show(4'b0001, P5, 10);
        show(4'b0010, P6, 10);
        show(4'b0000, 7'd0, 4);
        check("overwrite_frame", 32'(frames - f0), 32'd1);
        check("overwrite_digits", 32'(digits), 32'(12'b001_001_110_101));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
